// File: rtl/ntt_job_arbiter_if.sv
// Bundle between NTT client engines, the job arbiter and the shared NTT core.
// The arbiter connects through the slave modport; client/core side through master.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface ntt_job_arbiter_if #(
    parameter int unsigned REQ_CNT = 2,
    parameter int unsigned DW      = `DATA_WIDTH
);
    localparam int unsigned ID_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    logic [REQ_CNT-1:0]             req;
    logic [REQ_CNT-1:0]             req_valid;
    logic [REQ_CNT-1:0][1:0][DW-1:0] req_data;
    logic [REQ_CNT-1:0]             gnt;
    logic                           core_in_en;
    logic [1:0][DW-1:0]             core_in;
    logic                           core_out_en;
    logic [REQ_CNT-1:0]             rsp_en;
    logic                           busy;
    logic                           done;
    logic [ID_W-1:0]                done_id;
    logic                           err;

    modport master (
        output req, req_valid, req_data, core_out_en,
        input  gnt, core_in_en, core_in, rsp_en, busy, done, done_id, err
    );

    modport slave (
        input  req, req_valid, req_data, core_out_en,
        output gnt, core_in_en, core_in, rsp_en, busy, done, done_id, err
    );
endinterface

// File: rtl/ntt_job_arbiter.sv
// Round-robin arbiter sharing one NTT core between REQ_CNT engines, one polynomial job at a time.
// Optional drain watchdog enabled by defining NTT_ARB_WDT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module ntt_job_arbiter #(
    parameter int unsigned REQ_CNT    = 2,
    parameter int unsigned BEATS      = 128,
    parameter int unsigned WDT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    ntt_job_arbiter_if.slave    bus
);
    localparam int unsigned DW    = `DATA_WIDTH;
    localparam int unsigned ID_W  = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t             state_q, state_nxt;
    logic [REQ_CNT-1:0] gnt_q, gnt_nxt;
    logic [ID_W-1:0]    owner_q, owner_nxt;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_nxt;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_nxt;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_nxt;
    logic               core_in_en_q, core_in_en_nxt;
    logic [1:0][DW-1:0] core_in_q, core_in_nxt;
    logic               done_q, done_nxt;
    logic [ID_W-1:0]    done_id_q, done_id_nxt;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    int unsigned        scan_idx;
    logic               beat_acc;
    logic               out_inc;
    logic               wdt_trip;

    // Round-robin search starting at rr_ptr
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < REQ_CNT; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= REQ_CNT) scan_idx = scan_idx - REQ_CNT;
            if (!win_found && bus.req[ID_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(scan_idx);
            end
        end
    end

    assign beat_acc = (state_q == STREAM) && bus.req_valid[owner_q];
    assign out_inc  = (state_q != IDLE) && bus.core_out_en && (out_cnt_q != CNT_W'(BEATS));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (win_found) state_nxt = STREAM;
            STREAM:  if (beat_acc && (in_cnt_q == CNT_W'(BEATS - 1))) state_nxt = DRAIN;
            DRAIN:   if (out_cnt_q == CNT_W'(BEATS)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wdt_trip) state_nxt = IDLE;
    end

    // Next values of the registered outputs and counters
    always_comb begin
        gnt_nxt        = gnt_q;
        owner_nxt      = owner_q;
        rr_ptr_nxt     = rr_ptr_q;
        in_cnt_nxt     = in_cnt_q;
        out_cnt_nxt    = out_cnt_q;
        core_in_en_nxt = 1'b0;
        core_in_nxt    = '0;
        done_nxt       = 1'b0;
        done_id_nxt    = done_id_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt     = REQ_CNT'(1) << win_idx;
                    owner_nxt   = win_idx;
                    rr_ptr_nxt  = (32'(win_idx) == REQ_CNT - 1) ? '0 : win_idx + 1'b1;
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                end
            end
            STREAM: begin
                core_in_en_nxt = bus.req_valid[owner_q];
                core_in_nxt    = bus.req_data[owner_q];
                if (beat_acc) in_cnt_nxt = in_cnt_q + 1'b1;
            end
            DRAIN: begin
                if (out_cnt_q == CNT_W'(BEATS)) gnt_nxt = '0;
            end
            default: gnt_nxt = '0;
        endcase
        // Done fires on the out beat that completes the job; the following cycle drops gnt
        if (out_inc) begin
            out_cnt_nxt = out_cnt_q + 1'b1;
            if (out_cnt_q == CNT_W'(BEATS - 1)) begin
                done_nxt    = 1'b1;
                done_id_nxt = owner_q;
            end
        end
        if (wdt_trip) gnt_nxt = '0;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q        <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            core_in_en_q <= 1'b0;
            core_in_q    <= '0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
        end else begin
            gnt_q        <= gnt_nxt;
            owner_q      <= owner_nxt;
            rr_ptr_q     <= rr_ptr_nxt;
            in_cnt_q     <= in_cnt_nxt;
            out_cnt_q    <= out_cnt_nxt;
            core_in_en_q <= core_in_en_nxt;
            core_in_q    <= core_in_nxt;
            done_q       <= done_nxt;
            done_id_q    <= done_id_nxt;
        end
    end

`ifdef NTT_ARB_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_q;
    logic             err_q;

    // Counts DRAIN cycles since the last core output beat
    assign wdt_trip = (state_q == DRAIN) && !bus.core_out_en &&
                      (out_cnt_q != CNT_W'(BEATS)) &&
                      (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state_q == DRAIN) && !bus.core_out_en) wdt_cnt_q <= wdt_cnt_q + 1'b1;
            else                                        wdt_cnt_q <= '0;
            if (wdt_trip) err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_wdt;
    assign unused_wdt = |32'(WDT_CYCLES);
    assign wdt_trip   = 1'b0;
    assign bus.err    = 1'b0;
`endif

    assign bus.gnt        = gnt_q;
    assign bus.core_in_en = core_in_en_q;
    assign bus.core_in    = core_in_q;
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
    assign bus.busy       = (state_q != IDLE);
    // Core output beats go straight back to the owner; gnt is zero in IDLE
    assign bus.rsp_en     = gnt_q & {REQ_CNT{bus.core_out_en}};

endmodule
